sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_SIZE, default 18, SRAM word address width.
REQ-002 Parameter: DATA_SIZE, default 16, SRAM data width.
REQ-003 Parameter: TAG_DEPTH, default 4, max outstanding reads (power of two, >=2).
REQ-004 Port: a_clk  input  1  single clock; all state on rising edge.
REQ-005 Port: a_rst  input  1  reset, asynchronous, active-low.
REQ-006 Ports: cN_req  input  1  client N (N=0,1) request; held with its fields until cN_ready.
REQ-007 Ports: cN_rd  input  1  client N: 1=read, 0=write.
REQ-008 Ports: cN_addr  input  ADDR_SIZE  client N word address.
REQ-009 Ports: cN_be  input  2  client N byte enables (writes only).
REQ-010 Ports: cN_wr_data  input  DATA_SIZE  client N write data.
REQ-011 Ports: cN_ready  output  1  client N request accepted by SRAM this cycle.
REQ-012 Ports: cN_rd_data_vld  output  1  read data for client N valid this cycle.
REQ-013 Port: c_rd_data  output  DATA_SIZE  read data, shared by both clients.
REQ-014 Ports: sram_req, sram_rd  output  1  request/read strobe to SRAM core.
REQ-015 Ports: sram_addr  output  ADDR_SIZE, sram_be  output  2, sram_wr_data  output  DATA_SIZE.
REQ-016 Ports: sram_ready, sram_rd_data_vld  input  1; sram_rd_data  input  DATA_SIZE.
REQ-017 Port: rd_err  output  1  sticky: read data arrived with no outstanding tag.

Function
REQ-018 FSM shall have states IDLE and BUSY; sram_req shall equal (state==BUSY), registered.
REQ-019 In IDLE, a client shall be eligible when cN_req=1 and (cN_rd=0 or tag count < TAG_DEPTH).
REQ-020 In IDLE with one eligible client, that client shall be granted; with two, the client not equal to last_grant shall be granted.
REQ-021 On grant, next edge shall: register sram_addr/sram_rd/sram_wr_data from client, sram_be = cN_be for writes and 2'b11 for reads, set grant and last_grant, enter BUSY.
REQ-022 Grant-to-SRAM latency: client request sampled in IDLE at cycle t -> sram_req=1 at t+1.
REQ-023 In BUSY, sram_* outputs shall remain stable until sram_ready=1.
REQ-024 cN_ready shall be combinational: (state==BUSY) & sram_ready & (grant==N); never both high.
REQ-025 On BUSY & sram_ready, next state shall be IDLE; minimum 2 cycles per transaction.
REQ-026 On BUSY & sram_ready & sram_rd, grant ID shall be pushed to the tag FIFO.
REQ-027 On sram_rd_data_vld with FIFO non-empty: head popped; cN_rd_data_vld = 1 for N = head, combinational, same cycle.
REQ-028 c_rd_data shall equal sram_rd_data combinationally.
REQ-029 Simultaneous push and pop shall leave count unchanged; head/tail pointers wrap modulo TAG_DEPTH.
REQ-030 sram_rd_data_vld with FIFO empty: no cN_rd_data_vld, count unchanged, rd_err set until reset.
REQ-031 Tag count == TAG_DEPTH shall block read grants only; writes still granted.
REQ-032 Reads shall return to clients in issue order; no reordering.
REQ-033 Client dropping cN_req while in BUSY for its own grant shall not abort the SRAM transaction.

Reset
REQ-034 a_rst=0 shall immediately force: state=IDLE, sram_req=0, sram_rd=0, sram_addr=0, sram_be=0, sram_wr_data=0, grant=0, last_grant=1, tag count/pointers=0, rd_err=0.
REQ-035 Reset mid-transaction shall discard the in-flight request and all outstanding tags; read data arriving after reset release shall set rd_err.
REQ-036 Deassertion of a_rst shall be honoured on the next a_clk edge; first grant on or after that edge.

Verification
REQ-037 Single write: c0 req write addr 0x00010, data 0xBEEF, be 2'b01; sram_ready 1 cycle after sram_req -> sram_addr=0x00010, sram_be=01, c0_ready pulse 1 cycle, no tag pushed.
REQ-038 Contention: c0 and c1 both request continuously from reset -> grants alternate c0,c1,c0,c1; each cN_ready one cycle; never simultaneous.
REQ-039 Read routing: c1 read 0x00020 then c0 read 0x00030, SRAM returns 0x1111 then 0x2222 4 cycles after each accept -> c1_rd_data_vld with 0x1111, then c0_rd_data_vld with 0x2222.
REQ-040 Tag full: 4 reads accepted with no data returned, c0 read plus c1 write pending -> c1 write granted, c0 read stalled until first sram_rd_data_vld.
REQ-041 Spurious data: sram_rd_data_vld=1 with no outstanding read -> rd_err=1, both cN_rd_data_vld=0, rd_err held.
REQ-042 Reset mid-op: a_rst=0 while BUSY with 2 tags outstanding -> sram_req=0 same cycle; count=0; later returned data sets rd_err.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-client arbiter in front of a single-port SRAM core. While idle, it
//   grants one eligible client. Ties go to the client that was not granted
//   last. The granted request is registered onto the sram_* strobes and held
//   until the core asserts sram_ready. Read grants push the client ID into a
//   tag FIFO. Returning read data pops the FIFO and is routed to the client
//   that issued the oldest outstanding read.
//
// Ports
//   a_clk, a_rst            clock (rising edge), asynchronous active-low reset
//   cN_req/rd/addr/be/wr_data
//                           client N request; fields are held until cN_ready
//   cN_ready                client N request accepted by the SRAM this cycle
//   cN_rd_data_vld          read data on c_rd_data belongs to client N
//   c_rd_data               read data shared by both clients (pass-through)
//   sram_req/rd/addr/be/wr_data
//                           registered request to the SRAM core
//   sram_ready              SRAM accepts the current request
//   sram_rd_data_vld/rd_data
//                           read data returned by the SRAM core
//   rd_err                  sticky; read data arrived with no outstanding tag
module sram_arbiter #(
  parameter int unsigned ADDR_SIZE = 18,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                 a_clk,
  input  logic                 a_rst,
  // client 0
  input  logic                 c0_req,
  input  logic                 c0_rd,
  input  logic [ADDR_SIZE-1:0] c0_addr,
  input  logic [1:0]           c0_be,
  input  logic [DATA_SIZE-1:0] c0_wr_data,
  output logic                 c0_ready,
  output logic                 c0_rd_data_vld,
  // client 1
  input  logic                 c1_req,
  input  logic                 c1_rd,
  input  logic [ADDR_SIZE-1:0] c1_addr,
  input  logic [1:0]           c1_be,
  input  logic [DATA_SIZE-1:0] c1_wr_data,
  output logic                 c1_ready,
  output logic                 c1_rd_data_vld,
  // shared read data
  output logic [DATA_SIZE-1:0] c_rd_data,
  // SRAM core side
  output logic                 sram_req,
  output logic                 sram_rd,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [1:0]           sram_be,
  output logic [DATA_SIZE-1:0] sram_wr_data,
  input  logic                 sram_ready,
  input  logic                 sram_rd_data_vld,
  input  logic [DATA_SIZE-1:0] sram_rd_data,
  output logic                 rd_err
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_grant;
  logic                 r_last_grant;
  logic                 r_sram_rd;
  logic [ADDR_SIZE-1:0] r_sram_addr;
  logic [1:0]           r_sram_be;
  logic [DATA_SIZE-1:0] r_sram_wr_data;

  logic [TAG_DEPTH-1:0] r_tag;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rd_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_elig0;
  logic                 w_elig1;
  logic                 w_grant_vld;
  logic                 w_grant_id;
  logic                 w_sel_rd;
  logic [ADDR_SIZE-1:0] w_sel_addr;
  logic [1:0]           w_sel_be;
  logic [DATA_SIZE-1:0] w_sel_wr_data;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_id;

  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == '0);

  // A full tag FIFO blocks only reads; writes need no tag.
  assign w_elig0 = c0_req & (~c0_rd | ~w_full);
  assign w_elig1 = c1_req & (~c1_rd | ~w_full);

  // Next-state and grant selection
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_elig0 && w_elig1) begin
          w_grant_vld = 1'b1;
          w_grant_id  = ~r_last_grant;
        end else if (w_elig0) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b0;
        end else if (w_elig1) begin
          w_grant_vld = 1'b1;
          w_grant_id  = 1'b1;
        end
        if (w_grant_vld) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (sram_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields of the client being granted
  assign w_sel_rd      = w_grant_id ? c1_rd      : c0_rd;
  assign w_sel_addr    = w_grant_id ? c1_addr    : c0_addr;
  assign w_sel_be      = w_grant_id ? c1_be      : c0_be;
  assign w_sel_wr_data = w_grant_id ? c1_wr_data : c0_wr_data;

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request registers are only loaded from IDLE, so they hold steady for
  // the whole BUSY phase even if the client drops or changes its request.
  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      r_grant        <= 1'b0;
      r_last_grant   <= 1'b1;
      r_sram_rd      <= 1'b0;
      r_sram_addr    <= '0;
      r_sram_be      <= '0;
      r_sram_wr_data <= '0;
    end else if (w_grant_vld) begin
      r_grant        <= w_grant_id;
      r_last_grant   <= w_grant_id;
      r_sram_rd      <= w_sel_rd;
      r_sram_addr    <= w_sel_addr;
      r_sram_be      <= w_sel_rd ? 2'b11 : w_sel_be;
      r_sram_wr_data <= w_sel_wr_data;
    end
  end

  // Tag FIFO: one bit per outstanding read holding the issuing client ID.
  // Pointers wrap naturally because TAG_DEPTH is a power of two.
  assign w_accept  = (r_state == S_BUSY) & sram_ready;
  assign w_push    = w_accept & r_sram_rd;
  assign w_pop     = sram_rd_data_vld & ~w_empty;
  assign w_head_id = r_tag[r_head];

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      r_tag  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_tail] <= r_grant;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge a_clk or negedge a_rst) begin
    if (!a_rst) begin
      r_rd_err <= 1'b0;
    end else if (sram_rd_data_vld && w_empty) begin
      r_rd_err <= 1'b1;
    end
  end

  assign sram_req       = (r_state == S_BUSY);
  assign sram_rd        = r_sram_rd;
  assign sram_addr      = r_sram_addr;
  assign sram_be        = r_sram_be;
  assign sram_wr_data   = r_sram_wr_data;

  assign c0_ready       = w_accept & ~r_grant;
  assign c1_ready       = w_accept &  r_grant;

  assign c0_rd_data_vld = w_pop & ~w_head_id;
  assign c1_rd_data_vld = w_pop &  w_head_id;
  assign c_rd_data      = sram_rd_data;

  assign rd_err         = r_rd_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter (default parameters). Inputs are driven
//   on the falling clock edge; outputs are checked on that edge (plus #1
//   when combinational inputs have just changed).
module tb_sram_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic          a_clk;
  logic          a_rst;
  logic          c0_req, c0_rd, c0_ready, c0_rd_data_vld;
  logic [AW-1:0] c0_addr;
  logic [1:0]    c0_be;
  logic [DW-1:0] c0_wr_data;
  logic          c1_req, c1_rd, c1_ready, c1_rd_data_vld;
  logic [AW-1:0] c1_addr;
  logic [1:0]    c1_be;
  logic [DW-1:0] c1_wr_data;
  logic [DW-1:0] c_rd_data;
  logic          sram_req, sram_rd;
  logic [AW-1:0] sram_addr;
  logic [1:0]    sram_be;
  logic [DW-1:0] sram_wr_data;
  logic          sram_ready, sram_rd_data_vld;
  logic [DW-1:0] sram_rd_data;
  logic          rd_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  sram_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .TAG_DEPTH(4)) dut (
    .a_clk(a_clk), .a_rst(a_rst),
    .c0_req(c0_req), .c0_rd(c0_rd), .c0_addr(c0_addr), .c0_be(c0_be),
    .c0_wr_data(c0_wr_data), .c0_ready(c0_ready), .c0_rd_data_vld(c0_rd_data_vld),
    .c1_req(c1_req), .c1_rd(c1_rd), .c1_addr(c1_addr), .c1_be(c1_be),
    .c1_wr_data(c1_wr_data), .c1_ready(c1_ready), .c1_rd_data_vld(c1_rd_data_vld),
    .c_rd_data(c_rd_data),
    .sram_req(sram_req), .sram_rd(sram_rd), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_wr_data(sram_wr_data), .sram_ready(sram_ready),
    .sram_rd_data_vld(sram_rd_data_vld), .sram_rd_data(sram_rd_data),
    .rd_err(rd_err)
  );

  initial begin
    a_clk = 1'b0;
    forever #5 a_clk = ~a_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge a_clk);
    @(negedge a_clk);
  endtask

  initial begin
    a_rst = 1'b0;
    c0_req = 1'b0; c0_rd = 1'b0; c0_addr = '0; c0_be = '0; c0_wr_data = '0;
    c1_req = 1'b0; c1_rd = 1'b0; c1_addr = '0; c1_be = '0; c1_wr_data = '0;
    sram_ready = 1'b0; sram_rd_data_vld = 1'b0; sram_rd_data = '0;

    // ---- reset state
    @(negedge a_clk);
    chk("rst_sram_req",  32'(sram_req), 0);
    chk("rst_sram_rd",   32'(sram_rd), 0);
    chk("rst_sram_addr", 32'(sram_addr), 0);
    chk("rst_sram_be",   32'(sram_be), 0);
    chk("rst_sram_wd",   32'(sram_wr_data), 0);
    chk("rst_rd_err",    32'(rd_err), 0);
    chk("rst_ready",     32'({c0_ready, c1_ready}), 0);
    a_rst = 1'b1;

    // ---- single write from c0; c0 drops its request mid-transaction
    c0_req = 1'b1; c0_rd = 1'b0; c0_addr = 18'h00010; c0_wr_data = 16'hBEEF; c0_be = 2'b01;
    tick();
    chk("wr_sram_req",  32'(sram_req), 1);
    chk("wr_sram_addr", 32'(sram_addr), 32'h10);
    chk("wr_sram_be",   32'(sram_be), 32'h1);
    chk("wr_sram_wd",   32'(sram_wr_data), 32'hBEEF);
    chk("wr_sram_rd",   32'(sram_rd), 0);
    chk("wr_wait_rdy",  32'(c0_ready), 0);
    c0_req = 1'b0;
    tick();
    chk("wr_hold_req",  32'(sram_req), 1);
    chk("wr_hold_addr", 32'(sram_addr), 32'h10);
    sram_ready = 1'b1; #1;
    chk("wr_c0_ready",  32'(c0_ready), 1);
    chk("wr_c1_ready",  32'(c1_ready), 0);
    tick();
    sram_ready = 1'b0; #1;
    chk("wr_done_req",  32'(sram_req), 0);
    chk("wr_done_rdy",  32'(c0_ready), 0);

    // ---- spurious read data (no tag was pushed by the write)
    sram_rd_data_vld = 1'b1; sram_rd_data = 16'hDEAD; #1;
    chk("sp_c0_vld", 32'(c0_rd_data_vld), 0);
    chk("sp_c1_vld", 32'(c1_rd_data_vld), 0);
    chk("sp_data",   32'(c_rd_data), 32'hDEAD);
    tick();
    sram_rd_data_vld = 1'b0; #1;
    chk("sp_rd_err", 32'(rd_err), 1);
    tick();
    chk("sp_rd_err_held", 32'(rd_err), 1);
    a_rst = 1'b0; #1;
    chk("rst2_rd_err", 32'(rd_err), 0);
    a_rst = 1'b1;

    // ---- contention: both clients request continuously
    c0_req = 1'b1; c0_rd = 1'b0; c0_addr = 18'h00100; c0_be = 2'b11; c0_wr_data = 16'h0C00;
    c1_req = 1'b1; c1_rd = 1'b0; c1_addr = 18'h00200; c1_be = 2'b10; c1_wr_data = 16'h0C11;
    sram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ct_c0_ready", 32'(c0_ready), (i % 2 == 0) ? 1 : 0);
      chk("ct_c1_ready", 32'(c1_ready), (i % 2 == 1) ? 1 : 0);
      chk("ct_addr",     32'(sram_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
      tick();
      chk("ct_idle_req", 32'(sram_req), 0);
      chk("ct_idle_rdy", 32'({c0_ready, c1_ready}), 0);
    end
    c0_req = 1'b0; c1_req = 1'b0; sram_ready = 1'b0;

    // ---- read routing: c1 read, then c0 read, data returned in order
    c1_req = 1'b1; c1_rd = 1'b1; c1_addr = 18'h00020;
    tick();
    chk("rr_rd",   32'(sram_rd), 1);
    chk("rr_be",   32'(sram_be), 32'h3);
    chk("rr_addr", 32'(sram_addr), 32'h20);
    sram_ready = 1'b1; #1;
    chk("rr_c1_ready", 32'(c1_ready), 1);
    tick();
    c1_req = 1'b0;
    c0_req = 1'b1; c0_rd = 1'b1; c0_addr = 18'h00030;
    tick();
    chk("rr_c0_ready", 32'(c0_ready), 1);
    chk("rr_addr2",    32'(sram_addr), 32'h30);
    tick();
    c0_req = 1'b0; sram_ready = 1'b0;
    tick();
    sram_rd_data_vld = 1'b1; sram_rd_data = 16'h1111; #1;
    chk("rr_v1_c1", 32'(c1_rd_data_vld), 1);
    chk("rr_v1_c0", 32'(c0_rd_data_vld), 0);
    chk("rr_d1",    32'(c_rd_data), 32'h1111);
    tick();
    sram_rd_data_vld = 1'b0;
    tick();
    sram_rd_data_vld = 1'b1; sram_rd_data = 16'h2222; #1;
    chk("rr_v2_c0", 32'(c0_rd_data_vld), 1);
    chk("rr_v2_c1", 32'(c1_rd_data_vld), 0);
    chk("rr_d2",    32'(c_rd_data), 32'h2222);
    tick();
    sram_rd_data_vld = 1'b0;

    // ---- tag full: four c0 reads outstanding, c1 write still granted
    c0_req = 1'b1; c0_rd = 1'b1; c0_addr = 18'h00050; sram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tf_acc", 32'(c0_ready), 1);
      tick();
    end
    c1_req = 1'b1; c1_rd = 1'b0; c1_addr = 18'h00040; c1_wr_data = 16'h5A5A; c1_be = 2'b10;
    tick();
    chk("tf_wr_grant", 32'(c1_ready), 1);
    chk("tf_wr_rd",    32'(sram_rd), 0);
    chk("tf_wr_addr",  32'(sram_addr), 32'h40);
    chk("tf_wr_be",    32'(sram_be), 32'h2);
    chk("tf_c0_block", 32'(c0_ready), 0);
    tick();
    c1_req = 1'b0;
    tick();
    chk("tf_stall",  32'(sram_req), 0);
    tick();
    chk("tf_stall2", 32'(sram_req), 0);
    sram_rd_data_vld = 1'b1; sram_rd_data = 16'hAAAA; #1;
    chk("tf_pop", 32'(c0_rd_data_vld), 1);
    tick();
    sram_rd_data_vld = 1'b0; #1;
    chk("tf_no_grant_yet", 32'(sram_req), 0);
    tick();
    chk("tf_rd_grant", 32'(sram_req), 1);
    chk("tf_rd_rd",    32'(sram_rd), 1);
    chk("tf_rd_ready", 32'(c0_ready), 1);
    c0_req = 1'b0;
    tick();
    sram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sram_rd_data_vld = 1'b1; sram_rd_data = 16'(16'h0100 + i); #1;
      chk("tf_drain_c0", 32'(c0_rd_data_vld), 1);
      chk("tf_drain_c1", 32'(c1_rd_data_vld), 0);
      tick();
    end
    sram_rd_data_vld = 1'b0; #1;
    chk("tf_no_err", 32'(rd_err), 0);

    // ---- reset mid-operation with two reads outstanding
    c0_req = 1'b1; c0_rd = 1'b1; c0_addr = 18'h00060; sram_ready = 1'b1;
    tick(); tick(); tick(); tick();
    sram_ready = 1'b0;
    tick();
    chk("rm_busy", 32'(sram_req), 1);
    a_rst = 1'b0; #1;
    chk("rm_req",  32'(sram_req), 0);
    chk("rm_rd",   32'(sram_rd), 0);
    chk("rm_addr", 32'(sram_addr), 0);
    chk("rm_be",   32'(sram_be), 0);
    c0_req = 1'b0;
    tick();
    a_rst = 1'b1;
    tick();
    chk("rm_idle", 32'(sram_req), 0);
    sram_rd_data_vld = 1'b1; sram_rd_data = 16'h3333; #1;
    chk("rm_c0_vld", 32'(c0_rd_data_vld), 0);
    chk("rm_c1_vld", 32'(c1_rd_data_vld), 0);
    tick();
    sram_rd_data_vld = 1'b0; #1;
    chk("rm_rd_err", 32'(rd_err), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
